// File: rtl/blink_pkg.sv
// Shared definitions for the LED blink scheduler.
// Mode encodings as seen on the SW pins and the mode output.
package blink_pkg;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_SLOW  = 2'b01;
  localparam logic [1:0] MODE_FAST  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  typedef enum logic [1:0] {
    ST_OFF   = MODE_OFF,
    ST_SLOW  = MODE_SLOW,
    ST_FAST  = MODE_FAST,
    ST_BURST = MODE_BURST
  } mode_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing fast and slow (frame) ticks.
// slow_tick always coincides with a fast_tick.
module tick_gen #(
  parameter int FAST_LOG2 = 20,
  parameter int SLOW_LOG2 = 24
) (
  input  logic clk,
  input  logic rst_n,
  output logic fast_tick,
  output logic slow_tick
);

  logic [SLOW_LOG2-1:0] cnt;

  // prescale counter, wraps naturally at all ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt + SLOW_LOG2'(1);
  end

  assign fast_tick = &cnt[FAST_LOG2-1:0];
  assign slow_tick = &cnt;

endmodule

// File: rtl/blink_scheduler.sv
// LED mode scheduler: switch sync, frame-aligned mode FSM,
// and burst pulse counter driving a single registered LED.
module blink_scheduler
  import blink_pkg::*;
#(
  parameter int FAST_LOG2 = 20,
  parameter int SLOW_LOG2 = 24,
  parameter int BURST_LEN = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] SW,
  output logic       out,
  output logic [1:0] mode,
  output logic       frame
);

  localparam int BCW = $clog2(2*BURST_LEN+1);
  localparam logic [BCW-1:0] BURST_MAX = BCW'(2*BURST_LEN);

  logic           fast_tick;
  logic           slow_tick;
  logic [1:0]     sw_m;
  logic [1:0]     sw_s;
  mode_t          state;
  mode_t          state_n;
  logic           out_n;
  logic [BCW-1:0] burst_cnt;
  logic [BCW-1:0] bc_n;

  tick_gen #(
    .FAST_LOG2(FAST_LOG2),
    .SLOW_LOG2(SLOW_LOG2)
  ) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .fast_tick(fast_tick),
    .slow_tick(slow_tick)
  );

  // two-flop synchronizer for the asynchronous switches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_m <= 2'b00;
      sw_s <= 2'b00;
    end else begin
      sw_m <= SW;
      sw_s <= sw_m;
    end
  end

  // mode, LED, burst counter and frame pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_OFF;
      out       <= 1'b0;
      burst_cnt <= '0;
      frame     <= 1'b0;
    end else begin
      state     <= state_n;
      out       <= out_n;
      burst_cnt <= bc_n;
      frame     <= slow_tick;
    end
  end

  // next state: modes switch only on frame boundaries
  always_comb begin
    state_n = state;
    out_n   = out;
    bc_n    = burst_cnt;
    if (slow_tick) begin
      state_n = mode_t'(sw_s);
      if (sw_s != state) begin
        out_n = 1'b0;
        bc_n  = '0;
      end else begin
        unique case (state)
          ST_OFF:   out_n = 1'b0;
          ST_SLOW:  out_n = ~out;
          ST_FAST:  out_n = ~out;
          ST_BURST: begin
            out_n = 1'b0;
            bc_n  = '0;
          end
        endcase
      end
    end else if (fast_tick) begin
      unique case (state)
        ST_OFF:   out_n = 1'b0;
        ST_SLOW:  out_n = out;
        ST_FAST:  out_n = ~out;
        ST_BURST: begin
          if (burst_cnt < BURST_MAX) begin
            out_n = ~out;
            bc_n  = burst_cnt + BCW'(1);
          end else begin
            out_n = 1'b0;
          end
        end
      endcase
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_blink_scheduler.sv
// Bench for blink_scheduler: vector table, directed corners,
// and random switch traffic against a frame-position model.
module tb_blink_scheduler;

  localparam int FL = 2;
  localparam int SL = 5;
  localparam int BL = 3;
  localparam int FP = 1 << FL;
  localparam int FR = 1 << SL;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] SW = 2'b00;
  logic       out;
  logic [1:0] mode;
  logic       frame;

  int vectors = 0;
  int miscompares = 0;

  int         k;
  logic [1:0] m_mode;
  logic       m_out;
  logic       m_frame;
  logic [1:0] swq[$];

  typedef struct {
    logic [1:0] sw;
    int         n;
    logic [1:0] mode;
    logic       out;
    logic       frame;
  } vec_t;

  vec_t tbl[19];

  blink_scheduler #(
    .FAST_LOG2(FL),
    .SLOW_LOG2(SL),
    .BURST_LEN(BL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .SW   (SW),
    .out  (out),
    .mode (mode),
    .frame(frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [3:0] act,
                     input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)",
               nm, act, exp, k);
    end
  endtask

  // burst LED level at a given position inside the frame
  function automatic logic burst_level(int c);
    int p;
    p = c / FP;
    return (p % 2 == 1) && (p < 2*BL);
  endfunction

  task automatic model_reset();
    k = 0;
    m_mode = 2'b00;
    m_out = 1'b0;
    m_frame = 1'b0;
    swq = {2'b00, 2'b00};
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_out", {3'b0, out}, 4'h0);
    chk("rst_mode", {2'b0, mode}, 4'h0);
    chk("rst_frame", {3'b0, frame}, 4'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step();
    logic [1:0] sws;
    int c;
    bit slow;
    bit fast;
    sws = swq.pop_front();
    swq.push_back(SW);
    c = k % FR;
    slow = (c == FR-1);
    fast = (c % FP) == FP-1;
    @(posedge clk);
    #1;
    if (slow) begin
      if (sws != m_mode) m_out = 1'b0;
      else if (m_mode == 2'd1 || m_mode == 2'd2)
        m_out = !m_out;
      else m_out = 1'b0;
      m_mode = sws;
    end else if (fast && m_mode == 2'd2) begin
      m_out = !m_out;
    end
    if (m_mode == 2'd3) m_out = burst_level((c+1) % FR);
    if (m_mode == 2'd0) m_out = 1'b0;
    m_frame = slow;
    k++;
    chk("out", {3'b0, out}, {3'b0, m_out});
    chk("mode", {2'b0, mode}, {2'b0, m_mode});
    chk("frame", {3'b0, frame}, {3'b0, m_frame});
  endtask

  initial begin
    tbl = '{
      '{2'd1, 31, 2'd0, 1'b0, 1'b0},
      '{2'd1,  1, 2'd1, 1'b0, 1'b1},
      '{2'd1,  1, 2'd1, 1'b0, 1'b0},
      '{2'd1, 31, 2'd1, 1'b1, 1'b1},
      '{2'd2, 31, 2'd1, 1'b1, 1'b0},
      '{2'd2,  1, 2'd2, 1'b0, 1'b1},
      '{2'd2,  4, 2'd2, 1'b1, 1'b0},
      '{2'd3,  4, 2'd2, 1'b0, 1'b0},
      '{2'd3, 24, 2'd3, 1'b0, 1'b1},
      '{2'd3,  4, 2'd3, 1'b1, 1'b0},
      '{2'd3,  4, 2'd3, 1'b0, 1'b0},
      '{2'd3,  4, 2'd3, 1'b1, 1'b0},
      '{2'd3,  4, 2'd3, 1'b0, 1'b0},
      '{2'd3,  4, 2'd3, 1'b1, 1'b0},
      '{2'd3,  4, 2'd3, 1'b0, 1'b0},
      '{2'd3,  4, 2'd3, 1'b0, 1'b0},
      '{2'd3,  4, 2'd3, 1'b0, 1'b1},
      '{2'd3,  4, 2'd3, 1'b1, 1'b0},
      '{2'd0, 28, 2'd0, 1'b0, 1'b1}
    };

    #2;
    do_reset();

    // fixed vector table from reset
    for (int i = 0; i < 19; i++) begin
      SW = tbl[i].sw;
      repeat (tbl[i].n) step();
      chk("tbl_mode", {2'b0, mode}, {2'b0, tbl[i].mode});
      chk("tbl_out", {3'b0, out}, {3'b0, tbl[i].out});
      chk("tbl_frame", {3'b0, frame}, {3'b0, tbl[i].frame});
    end

    // off mode with a short glitch between boundaries
    do_reset();
    SW = 2'd0;
    repeat (10) step();
    SW = 2'd2;
    repeat (5) step();
    SW = 2'd0;
    repeat (60) step();
    chk("glitch_mode", {2'b0, mode}, 4'h0);
    chk("glitch_out", {3'b0, out}, 4'h0);

    // reset pulse while fast mode is driving high
    do_reset();
    SW = 2'd2;
    repeat (36) step();
    chk("fast_hi", {3'b0, out}, 4'h1);
    do_reset();
    repeat (31) step();
    chk("post_rst_mode0", {2'b0, mode}, 4'h0);
    step();
    chk("post_rst_mode2", {2'b0, mode}, 4'h2);

    // burst repeated over three same-mode frames
    do_reset();
    SW = 2'd3;
    repeat (32) step();
    for (int i = 0; i < 3*FR; i++) begin
      step();
      chk("burst_cnt_max",
          {3'b0, (dut.burst_cnt > 3'd6)}, 4'h0);
    end

    // random switch traffic with occasional resets
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 15) == 0)
        SW = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) do_reset();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
